inert_spi_ctrl: RTL
===================

# inert_spi_ctrl

Sequencer sitting directly upstream of the SPI monarch: it owns the monarch's `wrt`/`wt_data` inputs and consumes its `done`/`rd_data` outputs. After reset it waits out the inertial sensor's power-up time, writes three configuration registers, then services every data-ready interrupt by reading yaw-rate low and high bytes. It presents a signed 16-bit yaw rate with a one-cycle valid strobe to downstream integration logic.

## Interface
- `INIT_BITS`, default 16: width of the power-up wait counter; the wait is 2^INIT_BITS clk cycles.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `INT`  in  1  sensor data-ready, asynchronous to clk, active-high.
- `done`  in  1  SPI monarch transaction complete (level; cleared by the monarch one edge after `wrt`).
- `rd_data`  in  16  SPI monarch read data; only `[7:0]` is used.
- `wrt`  out  1  one-cycle pulse starting an SPI transaction.
- `cmd`  out  16  SPI command word driving monarch `wt_data`; held stable from `wrt` until `done`.
- `cfg_done`  out  1  high once all configuration writes finish; stays high until reset.
- `vld`  out  1  one-cycle pulse: `yaw_rt` updated this cycle.
- `yaw_rt`  out  16  signed yaw rate {high byte, low byte}.

## Operation
- States: INIT_WAIT, CFG1, CFG2, CFG3, WAIT_INT, RD_YL, RD_YH, plus one wait-for-`done` state after each issue (or a single shared wait state with a return-pointer register).
- INIT_WAIT: free-running INIT_BITS counter from 0; on terminal count (all ones), go to CFG1.
- CFG1/CFG2/CFG3: issue `cmd` = 0x0D02 (INT enable on data-ready), 0x1160 (gyro 416 Hz), 0x1440 (rounding), in that order; each waits for `done` before the next is issued.
- After CFG3 `done`: set `cfg_done`, go to WAIT_INT.
- WAIT_INT: when synchronized INT (`INT_s`) is high, issue RD_YL with `cmd` = 0xA600.
- RD_YL `done`: latch `rd_data[7:0]` into the low-byte holding register; issue RD_YH with `cmd` = 0xA700.
- RD_YH `done`: `yaw_rt` <= {`rd_data[7:0]`, low byte held}; `vld` = 1 for that one cycle; return to WAIT_INT.
- INT is level-sensitive. If `INT_s` is still high on return to WAIT_INT, a new read pair begins immediately, giving back-to-back reads.
- INT is ignored outside WAIT_INT, including during INIT_WAIT, configuration and an in-progress read pair.
- `done` is never sampled in the cycle `wrt` is high; the prior transaction's stale `done` must not advance the FSM.
- Reset at any point (mid-transaction included): all state returns to reset values, FSM to INIT_WAIT, full power-up wait and configuration re-run.

## Timing
- Reset values: `wrt`=0, `cmd`=0x0000, `cfg_done`=0, `vld`=0, `yaw_rt`=0x0000, low-byte holding register 0x00, counter 0, INT synchronizer flops 0.
- INT passes through two flops; `INT_s` lags INT by 2 clk edges.
- `wrt` is registered and asserted the cycle after the FSM decides to issue. `cmd` is valid no later than the cycle `wrt` is high.
- Next `wrt` is at least 1 cycle after the `done` rise that ends the previous transaction.
- Each transaction takes roughly 16×32 + overhead clk cycles of monarch time; this block adds at most 2 cycles per transaction.
- `vld` is registered: high the cycle after the RD_YH `done` is sampled, together with the new `yaw_rt`.
- `cfg_done` rises the cycle after the CFG3 `done` is sampled.

## Test plan
- Reset, INIT_BITS=4, bench SPI model: no `wrt` for 16 cycles after rst_n release, then exactly three `wrt` pulses with `cmd` 0x0D02, 0x1160, 0x1440 in order; `cfg_done` rises after the third `done`; `yaw_rt`=0 and `vld`=0 throughout.
- After config, pulse INT; model returns 0x34 for 0xA600 and 0x12 for 0xA700 -> one `vld` pulse, `yaw_rt`=0x1234.
- Negative yaw: model returns 0x00 and 0x80 -> `yaw_rt`=0x8000 (−32768), exactly one `vld`.
- INT held high continuously: consecutive read pairs with no idle gap beyond 2 cycles, one `vld` per pair, `cmd` alternating 0xA600/0xA700.
- INT asserted during INIT_WAIT and CFG2 then dropped before WAIT_INT: no read `cmd` issued and no `vld`.
- rst_n asserted mid-RD_YH: outputs return to reset values asynchronously; after release the full wait and three config writes repeat before any read.

Source files
------------

// File: rtl/inert_spi_ctrl_if.sv
// SPI monarch command/response bus between the inertial-sensor sequencer
// and the SPI monarch. The sequencer drives wrt/cmd and consumes done/rd_data.
interface inert_spi_ctrl_if;
  logic        wrt;      // one-cycle pulse starting a transaction
  logic [15:0] cmd;      // command word, held from wrt until done
  logic        done;     // transaction complete (level)
  logic [15:0] rd_data;  // read data, low byte meaningful

  // Sequencer side: issues commands, observes completion.
  modport master (
    output wrt,
    output cmd,
    input  done,
    input  rd_data
  );

  // SPI monarch side: accepts commands, reports completion and data.
  modport slave (
    input  wrt,
    input  cmd,
    output done,
    output rd_data
  );
endinterface : inert_spi_ctrl_if

// File: rtl/inert_spi_ctrl.sv
// Inertial sensor sequencer. After reset it waits out the sensor power-up
// time, writes three configuration registers through the SPI monarch, then
// services each data-ready interrupt by reading yaw-rate low and high bytes
// and presenting the signed 16-bit result with a one-cycle valid strobe.
module inert_spi_ctrl #(
  parameter int INIT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  INT,
  inert_spi_ctrl_if.master      spi,
  output logic                  cfg_done,
  output logic                  vld,
  output logic [15:0]           yaw_rt
);

  // Sensor command words.
  localparam logic [15:0] CMD_CFG1 = 16'h0D02;  // INT enable on data-ready
  localparam logic [15:0] CMD_CFG2 = 16'h1160;  // gyro 416 Hz
  localparam logic [15:0] CMD_CFG3 = 16'h1440;  // rounding
  localparam logic [15:0] CMD_RDYL = 16'hA600;  // read yaw-rate low byte
  localparam logic [15:0] CMD_RDYH = 16'hA700;  // read yaw-rate high byte

  // Configuration issue states are followed by a wait state each; the read
  // states double as wait states so back-to-back read pairs stay tight.
  typedef enum logic [3:0] {
    ST_INIT_WAIT = 4'd0,
    ST_CFG1      = 4'd1,
    ST_CFG1_W    = 4'd2,
    ST_CFG2      = 4'd3,
    ST_CFG2_W    = 4'd4,
    ST_CFG3      = 4'd5,
    ST_CFG3_W    = 4'd6,
    ST_WAIT_INT  = 4'd7,
    ST_RD_YL     = 4'd8,
    ST_RD_YH     = 4'd9
  } state_t;

  state_t                 state_q;
  logic [INIT_BITS-1:0]   cnt_q;
  logic [INIT_BITS-1:0]   cnt_d;
  logic                   cnt_term_s;
  logic                   int_meta_q;
  logic                   int_s_q;
  logic                   wrt_q;
  logic [15:0]            cmd_q;
  logic                   cfg_done_q;
  logic                   vld_q;
  logic [15:0]            yaw_q;
  logic [7:0]             low_q;
  logic                   done_ok_s;

  // Power-up counter increment and terminal-count detect.
  always_comb begin
    cnt_d      = cnt_q + {{(INIT_BITS-1){1'b0}}, 1'b1};
    cnt_term_s = &cnt_q;
  end

  // done is ignored while wrt is high: the monarch still shows the previous
  // transaction's done in that cycle and clears it one edge later.
  assign done_ok_s = spi.done & ~wrt_q;

  // Two-flop synchronizer for the asynchronous data-ready interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta_q <= 1'b0;
      int_s_q    <= 1'b0;
    end else begin
      int_meta_q <= INT;
      int_s_q    <= int_meta_q;
    end
  end

  // Sequencer FSM with registered wrt/cmd/cfg_done/vld/yaw_rt outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT_WAIT;
      cnt_q      <= {INIT_BITS{1'b0}};
      wrt_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      cfg_done_q <= 1'b0;
      vld_q      <= 1'b0;
      yaw_q      <= 16'h0000;
      low_q      <= 8'h00;
    end else begin
      wrt_q <= 1'b0;
      vld_q <= 1'b0;
      case (state_q)
        ST_INIT_WAIT: begin
          if (cnt_term_s) begin
            state_q <= ST_CFG1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_CFG1: begin
          wrt_q   <= 1'b1;
          cmd_q   <= CMD_CFG1;
          state_q <= ST_CFG1_W;
        end
        ST_CFG1_W: begin
          if (done_ok_s) begin
            state_q <= ST_CFG2;
          end else begin
            state_q <= ST_CFG1_W;
          end
        end
        ST_CFG2: begin
          wrt_q   <= 1'b1;
          cmd_q   <= CMD_CFG2;
          state_q <= ST_CFG2_W;
        end
        ST_CFG2_W: begin
          if (done_ok_s) begin
            state_q <= ST_CFG3;
          end else begin
            state_q <= ST_CFG2_W;
          end
        end
        ST_CFG3: begin
          wrt_q   <= 1'b1;
          cmd_q   <= CMD_CFG3;
          state_q <= ST_CFG3_W;
        end
        ST_CFG3_W: begin
          if (done_ok_s) begin
            cfg_done_q <= 1'b1;
            state_q    <= ST_WAIT_INT;
          end else begin
            state_q    <= ST_CFG3_W;
          end
        end
        ST_WAIT_INT: begin
          // Level-sensitive: a still-high interrupt starts the next pair.
          if (int_s_q) begin
            wrt_q   <= 1'b1;
            cmd_q   <= CMD_RDYL;
            state_q <= ST_RD_YL;
          end else begin
            state_q <= ST_WAIT_INT;
          end
        end
        ST_RD_YL: begin
          if (done_ok_s) begin
            low_q   <= spi.rd_data[7:0];
            wrt_q   <= 1'b1;
            cmd_q   <= CMD_RDYH;
            state_q <= ST_RD_YH;
          end else begin
            state_q <= ST_RD_YL;
          end
        end
        ST_RD_YH: begin
          if (done_ok_s) begin
            yaw_q   <= {spi.rd_data[7:0], low_q};
            vld_q   <= 1'b1;
            state_q <= ST_WAIT_INT;
          end else begin
            state_q <= ST_RD_YH;
          end
        end
        default: begin
          state_q <= ST_INIT_WAIT;
        end
      endcase
    end
  end

  assign spi.wrt  = wrt_q;
  assign spi.cmd  = cmd_q;
  assign cfg_done = cfg_done_q;
  assign vld      = vld_q;
  assign yaw_rt   = yaw_q;

endmodule : inert_spi_ctrl
